// File: rtl/heater_pwm_pkg.sv
// Shared definitions for the heater PWM generator: FSM encoding, datapath widths
// and the rising-slew helper used at each PWM period boundary.
// No ports; imported by heater_pwm_if, heater_pwm_tick and heater_pwm_gen.
package heater_pwm_pkg;

    localparam int DUTY_W     = 8;
    localparam int PHASE_W    = 8;
    localparam int FULL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Next applied duty: decreases take effect at once, increases are limited to
    // `step` per period. The sum is one bit wider than the duty so it cannot wrap.
    function automatic logic [DUTY_W-1:0] slew_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W:0]   step
    );
        logic [DUTY_W:0] sum;
        sum = {1'b0, cur} + step;
        if (tgt <= cur) begin
            return tgt;
        end else if (sum < {1'b0, tgt}) begin
            return sum[DUTY_W-1:0];
        end else begin
            return tgt;
        end
    endfunction

endpackage

// File: rtl/heater_pwm_if.sv
// Heater control bundle between the HPS-side PIO bits and the PWM generator.
// master drives duty_in/enable/fault_clear and observes the heater status;
// slave (the generator) does the opposite. No handshake: levels sampled every clk.
interface heater_pwm_if;
    import heater_pwm_pkg::*;

    logic [DUTY_W-1:0] duty_in;
    logic              enable;
    logic              fault_clear;
    logic              pwm_out;
    logic              fault;
    logic [DUTY_W-1:0] duty_active;
    logic              period_start;

    modport master (
        output duty_in, enable, fault_clear,
        input  pwm_out, fault, duty_active, period_start
    );

    modport slave (
        input  duty_in, enable, fault_clear,
        output pwm_out, fault, duty_active, period_start
    );
endinterface

// File: rtl/heater_pwm_tick.sv
// PWM timebase: prescaler (0..PRESCALE_DIV-1) feeding an 8-bit wrapping phase counter.
// Latency: tick/boundary are combinational from the registered counters.
// Backpressure: none, free-running. Ports: clk, reset -> tick_o, phase_o, boundary_o.
module heater_pwm_tick
    import heater_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 196
) (
    input  logic               clk,
    input  logic               reset,
    output logic               tick_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               boundary_o
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE_DIV - 1);

    logic [15:0]        pre_q;
    logic [PHASE_W-1:0] phase_q;

    assign tick_o     = (pre_q == PRE_LAST);
    assign phase_o    = phase_q;
    // Last tick of the last phase slot: the period ends on this cycle.
    assign boundary_o = tick_o && (phase_q == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            phase_q <= '0;
        end else if (tick_o) begin
            pre_q   <= '0;
            phase_q <= phase_q + 1'b1;
        end else begin
            pre_q   <= pre_q + 16'd1;
        end
    end

endmodule

// File: rtl/heater_pwm_gen.sv
// Heater MOSFET PWM: period-aligned duty updates, rising-slew limit, full-power watchdog.
// Latency: pwm_out registered 1 clk after the phase compare; duty applied at the period boundary.
// Backpressure: none. Ports: clk, reset, bus (slave: duty_in/enable/fault_clear in; pwm_out/fault/duty_active/period_start out).
module heater_pwm_gen
    import heater_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV     = 196,
    parameter int unsigned SLEW_STEP        = 8,
    parameter int unsigned FULL_THRESH      = 240,
    parameter int unsigned MAX_FULL_PERIODS = 5000
) (
    input  logic         clk,
    input  logic         reset,
    heater_pwm_if.slave  bus
);

    localparam int                    SUM_W    = DUTY_W + 1;
    localparam logic [DUTY_W:0]       SLEW9    = SUM_W'(SLEW_STEP);
    localparam logic [DUTY_W-1:0]     FULL_LVL = DUTY_W'(FULL_THRESH);
    localparam logic [FULL_CNT_W-1:0] FULL_MAX = FULL_CNT_W'(MAX_FULL_PERIODS);

    logic               tick;
    logic [PHASE_W-1:0] phase;
    logic               boundary;

    heater_pwm_tick #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .tick_o     (tick),
        .phase_o    (phase),
        .boundary_o (boundary)
    );

    state_e                  state_q;
    logic [DUTY_W-1:0]       duty_q;
    logic [DUTY_W-1:0]       duty_d;
    logic                    pwm_q;
    logic                    fault_q;
    logic                    ps_q;
    logic [FULL_CNT_W-1:0]   full_cnt_q;
    logic [FULL_CNT_W-1:0]   full_cnt_d;
    logic                    full_hit;

    assign duty_d = slew_next(duty_q, bus.duty_in, SLEW9);

    // Count judged on the duty of the period that is ending; saturates at the limit.
    always_comb begin
        full_cnt_d = '0;
        if (duty_q >= FULL_LVL) begin
            full_cnt_d = (full_cnt_q == FULL_MAX) ? full_cnt_q : full_cnt_q + 1'b1;
        end
    end
    assign full_hit = (full_cnt_d == FULL_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            fault_q    <= 1'b0;
            ps_q       <= 1'b0;
            full_cnt_q <= '0;
        end else begin
            ps_q <= boundary;
            case (state_q)
                ST_IDLE: begin
                    duty_q     <= '0;
                    pwm_q      <= 1'b0;
                    fault_q    <= 1'b0;
                    full_cnt_q <= '0;
                    // The entry boundary starts the first RUN period, so the
                    // requested duty (slew-limited from 0) is applied there.
                    if (boundary && bus.enable) begin
                        state_q <= ST_RUN;
                        duty_q  <= duty_d;
                    end
                end
                ST_RUN: begin
                    if (boundary && full_hit) begin
                        state_q    <= ST_FAULT;
                        fault_q    <= 1'b1;
                        duty_q     <= '0;
                        pwm_q      <= 1'b0;
                        full_cnt_q <= full_cnt_d;
                    end else if (!bus.enable) begin
                        // Shut off immediately, no wait for the period to end.
                        state_q <= ST_IDLE;
                        duty_q  <= '0;
                        pwm_q   <= 1'b0;
                    end else begin
                        pwm_q <= (phase < duty_q);
                        if (boundary) begin
                            duty_q     <= duty_d;
                            full_cnt_q <= full_cnt_d;
                        end
                    end
                end
                ST_FAULT: begin
                    duty_q  <= '0;
                    pwm_q   <= 1'b0;
                    fault_q <= 1'b1;
                    // Clearing requires the heater to be disabled first.
                    if (!bus.enable && bus.fault_clear) begin
                        state_q    <= ST_IDLE;
                        fault_q    <= 1'b0;
                        full_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    duty_q  <= '0;
                    pwm_q   <= 1'b0;
                end
            endcase
        end
    end

    // A period boundary is always a prescaler tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!boundary || tick);
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.fault        = fault_q;
    assign bus.duty_active  = duty_q;
    assign bus.period_start = ps_q;

endmodule
